// File: rtl/GPU_Shader_pkg.sv
// Shared shader-core types and sizes.
// Lane count, scratchpad depth and word type.
package GPU_Shader_pkg;
  localparam int lanes = 4;
  localparam int MEM_DEPTH = 64;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/lsu_scratchpad_ctrl_if.sv
// LSU request/response handshake bundle.
// master: requester side; slave: LSU side.
interface lsu_scratchpad_ctrl_if #(
  parameter int LANES = 4,
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int TAG_W = 4
);
  logic req_valid;
  logic req_ready;
  logic req_is_store;
  logic [LANES-1:0] req_mask;
  logic [AW-1:0] req_base;
  logic [LANES-1:0][AW-1:0] req_offset;
  logic [LANES-1:0][DW-1:0] req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic rsp_valid;
  logic rsp_ready;
  logic [LANES-1:0][DW-1:0] rsp_data;
  logic [LANES-1:0] rsp_mask;
  logic [LANES-1:0] rsp_fault;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_is_store, req_mask,
    output req_base, req_offset, req_wdata, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_mask,
    input  rsp_fault, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_is_store, req_mask,
    input  req_base, req_offset, req_wdata, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_mask,
    output rsp_fault, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/lsu_scratchpad_ctrl.sv
// Per-warp LD/ST front end for the lane scratchpad.
// Ports: clk, rst_n, bus (req/rsp), sp_* scratchpad side.
module lsu_scratchpad_ctrl
  import GPU_Shader_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int ISSUE_W = lanes,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  lsu_scratchpad_ctrl_if.slave bus,
  output logic [lanes-1:0] sp_write_en,
  output logic [lanes-1:0][ADDR_WIDTH-1:0] sp_write_addr,
  output logic [lanes-1:0][WORD_W-1:0] sp_write_data,
  output logic [lanes-1:0][ADDR_WIDTH-1:0] sp_read_addr,
  input  logic [lanes-1:0][WORD_W-1:0] sp_read_data
);

  localparam int NBEATS = lanes / ISSUE_W;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if (lanes % ISSUE_W != 0) begin : g_bad_issue
    $error("lanes must be a multiple of ISSUE_W");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_n;
  logic [BW-1:0] beat;
  logic accept;
  logic st;
  logic [lanes-1:0] mask;
  logic [ADDR_WIDTH-1:0] base;
  logic [lanes-1:0][ADDR_WIDTH-1:0] off;
  logic [lanes-1:0][WORD_W-1:0] wdata;
  logic [TAG_W-1:0] tag;
  logic [lanes-1:0][WORD_W-1:0] rdata;
  logic [lanes-1:0] rflt;

  logic [lanes-1:0][ADDR_WIDTH:0] addr;
  logic [lanes-1:0] act;
  logic [lanes-1:0] flt;

  assign bus.req_ready = (state == IDLE);
  assign accept = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data = rdata;
  assign bus.rsp_mask = mask;
  assign bus.rsp_fault = rflt;
  assign bus.rsp_tag = tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: if (beat == LAST) state_n = RESP;
      RESP: if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Extra address bit keeps base+offset overflow visible
  // to the range check instead of wrapping into range.
  always_comb begin
    addr = '0;
    act = '0;
    flt = '0;
    sp_write_en = '0;
    sp_write_addr = '0;
    sp_write_data = '0;
    sp_read_addr = '0;
    for (int i = 0; i < lanes; i++) begin
      addr[i] = {1'b0, base} + {1'b0, off[i]};
      act[i] = (state == BUSY) &&
               (int'(beat) == i / ISSUE_W);
      flt[i] = act[i] & mask[i] & (addr[i] >= DEPTH);
      if (act[i] && st) begin
        sp_write_en[i] = mask[i] & ~flt[i];
        sp_write_addr[i] = addr[i][ADDR_WIDTH-1:0];
        sp_write_data[i] = wdata[i];
      end
      if (act[i] && !st)
        sp_read_addr[i] = addr[i][ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      st <= 1'b0;
      mask <= '0;
      base <= '0;
      off <= '0;
      wdata <= '0;
      tag <= '0;
      rdata <= '0;
      rflt <= '0;
    end else if (accept) begin
      beat <= '0;
      st <= bus.req_is_store;
      mask <= bus.req_mask;
      base <= bus.req_base;
      off <= bus.req_offset;
      wdata <= bus.req_wdata;
      tag <= bus.req_tag;
      rdata <= '0;
      rflt <= '0;
    end else if (state == BUSY) begin
      beat <= (beat == LAST) ? '0 : beat + BW'(1);
      for (int i = 0; i < lanes; i++) begin
        if (flt[i]) rflt[i] <= 1'b1;
        if (act[i] && !st && mask[i] && !flt[i])
          rdata[i] <= sp_read_data[i];
      end
    end
  end

endmodule
